// File: rtl/uc_sequencer.sv
// Control unit and run/step/halt sequencer for the single-cycle microcontroller datapath.
// Decodes Opcode/z into datapath controls and gates each commit through the sequencer state.
module uc_sequencer #(
    parameter int unsigned CNT_W        = 16,
    parameter bit          ILLEGAL_HALT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    input  logic             run,
    input  logic             step_req,
    output logic             pc_en,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             step_ack,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {StIdle, StRun, StStep, StHalt} state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic             step_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic       dec_inc, dec_inm, dec_we3, dec_wez;
    logic [2:0] dec_op;
    logic       is_halt, is_undef, stop, active, commit, step_edge;

    always_comb begin
        dec_inc  = 1'b1;
        dec_inm  = 1'b0;
        dec_we3  = 1'b0;
        dec_wez  = 1'b0;
        dec_op   = 3'b000;
        is_halt  = 1'b0;
        is_undef = 1'b0;
        if (Opcode[5]) begin
            dec_op  = Opcode[4:2];
            dec_we3 = 1'b1;
            dec_wez = 1'b1;
        end else begin
            unique case (Opcode[4:0])
                5'd0: begin
                    dec_inm = 1'b1;
                    dec_we3 = 1'b1;
                end
                5'd1:    dec_inc  = 1'b0;
                5'd2:    dec_inc  = ~z;
                5'd3:    dec_inc  = z;
                5'd4:    dec_inc  = 1'b1;
                5'd5:    is_halt  = 1'b1;
                default: is_undef = 1'b1;
            endcase
        end
    end

    // Undefined opcodes either stop the core or fall through as a committing nop.
    assign stop      = is_halt | (is_undef & ILLEGAL_HALT);
    assign active    = reset & ((state_q == StRun) | (state_q == StStep));
    assign commit    = active & ~stop;
    assign step_edge = step_req & ~step_q;

    assign pc_en    = commit;
    assign s_inc    = commit ? dec_inc : 1'b1;
    assign s_inm    = commit & dec_inm;
    assign we3      = commit & dec_we3;
    assign wez      = commit & dec_wez;
    assign Op       = commit ? dec_op : 3'b000;
    assign step_ack = reset & (state_q == StStep);
    assign halted   = reset & (state_q == StHalt);
    assign illegal  = illegal_q;
    assign retired  = retired_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            step_q    <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            step_q <= step_req;
            if (commit && (retired_q != {CNT_W{1'b1}})) begin
                retired_q <= retired_q + CntOne;
            end
            if (active && is_undef) begin
                illegal_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (run)            state_q <= StRun;
                    else if (step_edge) state_q <= StStep;
                end
                StRun: begin
                    if (stop)      state_q <= StHalt;
                    else if (!run) state_q <= StIdle;
                end
                StStep: state_q <= stop ? StHalt : StIdle;
                StHalt: state_q <= StHalt;
            endcase
        end
    end

endmodule

// File: tb/tb_uc_sequencer.sv
// Self-checking bench for uc_sequencer: two instances (default, and CNT_W=4 with
// ILLEGAL_HALT=0) share stimulus and are compared every cycle against a behavioural model.
module tb_uc_sequencer;

    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MStep = 2;
    localparam int MHalt = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op = 6'd0;
    logic       z = 1'b0;
    logic       run = 1'b0;
    logic       step_req = 1'b0;

    logic        pc_en_a, s_inc_a, s_inm_a, we3_a, wez_a, step_ack_a, halted_a, illegal_a;
    logic [2:0]  op_a;
    logic [15:0] retired_a;
    logic        pc_en_b, s_inc_b, s_inm_b, we3_b, wez_b, step_ack_b, halted_b, illegal_b;
    logic [2:0]  op_b;
    logic [3:0]  retired_b;
    logic [9:0]  ctl_a, ctl_b;

    assign ctl_a = {pc_en_a, s_inc_a, s_inm_a, we3_a, wez_a, op_a, step_ack_a, halted_a};
    assign ctl_b = {pc_en_b, s_inc_b, s_inm_b, we3_b, wez_b, op_b, step_ack_b, halted_b};

    always #5 clk = ~clk;

    uc_sequencer dut_a (
        .clk(clk), .reset(rst), .Opcode(op), .z(z), .run(run), .step_req(step_req),
        .pc_en(pc_en_a), .s_inc(s_inc_a), .s_inm(s_inm_a), .we3(we3_a), .wez(wez_a),
        .Op(op_a), .step_ack(step_ack_a), .halted(halted_a), .illegal(illegal_a),
        .retired(retired_a)
    );

    uc_sequencer #(.CNT_W(4), .ILLEGAL_HALT(1'b0)) dut_b (
        .clk(clk), .reset(rst), .Opcode(op), .z(z), .run(run), .step_req(step_req),
        .pc_en(pc_en_b), .s_inc(s_inc_b), .s_inm(s_inm_b), .we3(we3_b), .wez(wez_b),
        .Op(op_b), .step_ack(step_ack_b), .halted(halted_b), .illegal(illegal_b),
        .retired(retired_b)
    );

    int n_chk = 0;
    int n_err = 0;
    int npc = 0;
    int nack = 0;

    int m_mode[2];
    bit m_ill[2];
    int m_cnt[2];
    bit m_prev[2];
    bit e_commit[2], e_stop[2], e_undef[2];
    bit m_ih[2] = '{1'b1, 1'b0};
    int m_max[2] = '{65535, 15};

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected control vector from the instruction set table and the sequencer mode.
    function automatic logic [9:0] model_ctl(input int mode, input bit ih, input bit rst_n,
                                             input logic [5:0] opc, input logic zz,
                                             output bit commit, output bit stops,
                                             output bit undef);
        bit inc = 1'b1, inm = 1'b0, w3 = 1'b0, wz = 1'b0, ack, hlt;
        logic [2:0] opf = 3'b000;
        bit is_halt = 1'b0;
        undef = 1'b0;
        if (opc >= 6'd32) begin
            opf = opc[4:2];
            w3 = 1'b1;
            wz = 1'b1;
        end else if (opc == 6'd0) begin
            inm = 1'b1;
            w3 = 1'b1;
        end else if (opc == 6'd1) inc = 1'b0;
        else if (opc == 6'd2) inc = !zz;
        else if (opc == 6'd3) inc = zz;
        else if (opc == 6'd5) is_halt = 1'b1;
        else if (opc != 6'd4) undef = 1'b1;
        stops = is_halt || (undef && ih);
        commit = rst_n && (mode == MRun || mode == MStep) && !stops;
        if (!commit) begin
            inc = 1'b1; inm = 1'b0; w3 = 1'b0; wz = 1'b0; opf = 3'b000;
        end
        ack = rst_n && mode == MStep;
        hlt = rst_n && mode == MHalt;
        return {commit, inc, inm, w3, wz, opf, ack, hlt};
    endfunction

    task automatic tick();
        logic [9:0] exp;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp = model_ctl(m_mode[i], m_ih[i], rst, op, z, e_commit[i], e_stop[i], e_undef[i]);
            check(i == 0 ? "ctl_a" : "ctl_b", i == 0 ? int'(ctl_a) : int'(ctl_b), int'(exp));
            check(i == 0 ? "illegal_a" : "illegal_b", i == 0 ? int'(illegal_a) : int'(illegal_b),
                  int'(m_ill[i]));
            check(i == 0 ? "retired_a" : "retired_b",
                  i == 0 ? int'(retired_a) : int'(retired_b), m_cnt[i]);
        end
        if (pc_en_a) npc++;
        if (step_ack_a) nack++;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_mode[i] = MIdle; m_cnt[i] = 0; m_ill[i] = 1'b0; m_prev[i] = 1'b0;
            end else begin
                if (e_commit[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
                if ((m_mode[i] == MRun || m_mode[i] == MStep) && e_undef[i]) m_ill[i] = 1'b1;
                case (m_mode[i])
                    MIdle: if (run) m_mode[i] = MRun;
                           else if (step_req && !m_prev[i]) m_mode[i] = MStep;
                    MRun:  if (e_stop[i]) m_mode[i] = MHalt;
                           else if (!run) m_mode[i] = MIdle;
                    MStep: m_mode[i] = e_stop[i] ? MHalt : MIdle;
                    default: m_mode[i] = MHalt;
                endcase
                m_prev[i] = step_req;
            end
        end
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int r;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = MIdle; m_cnt[i] = 0; m_ill[i] = 1'b0; m_prev[i] = 1'b0;
        end
        // Reset then idle: nothing may commit.
        tick();
        tick();
        rst = 1'b1;
        npc = 0;
        for (int i = 0; i < 10; i++) tick();
        check("t1_npc", npc, 0);
        check("t1_retired", int'(retired_a), 0);
        check("t1_halted", int'(halted_a), 0);

        // Single step of an ALU op held high for five cycles.
        op = 6'b100100;
        step_req = 1'b1;
        npc = 0;
        nack = 0;
        for (int i = 0; i < 5; i++) tick();
        check("t2_npc", npc, 1);
        check("t2_nack", nack, 1);
        check("t2_retired", int'(retired_a), 1);
        step_req = 1'b0;

        // Free-run stream ending in halt.
        reset_pulse();
        run = 1'b1;
        z = 1'b1;
        op = 6'b000000;
        tick();
        #1 check("t3_li_inm", int'(s_inm_a), 1);
        tick();
        op = 6'b101000;
        #1 check("t3_alu_op", int'(op_a), 2);
        tick();
        op = 6'b000010;
        #1 check("t3_jz_inc", int'(s_inc_a), 0);
        tick();
        op = 6'b000011;
        #1 check("t3_jnz_inc", int'(s_inc_a), 1);
        tick();
        op = 6'b000100;
        tick();
        op = 6'b000101;
        tick();
        for (int i = 0; i < 3; i++) begin
            op = 6'($urandom_range(0, 63));
            tick();
        end
        check("t3_retired", int'(retired_a), 5);
        check("t3_halted", int'(halted_a), 1);
        check("t3_pc_en", int'(pc_en_a), 0);

        // Undefined opcode under both ILLEGAL_HALT settings.
        reset_pulse();
        op = 6'b000111;
        tick();
        tick();
        check("t4_ill_a", int'(illegal_a), 1);
        check("t4_halt_a", int'(halted_a), 1);
        check("t4_ret_a", int'(retired_a), 0);
        check("t4_ill_b", int'(illegal_b), 1);
        check("t4_halt_b", int'(halted_b), 0);
        check("t4_ret_b", int'(retired_b), 1);

        // One-cycle reset out of HALT.
        reset_pulse();
        check("t6_halted", int'(halted_a), 0);
        check("t6_retired", int'(retired_a), 0);
        check("t6_illegal", int'(illegal_a), 0);

        // Counter saturation on the narrow instance, then drop run.
        reset_pulse();
        op = 6'b000100;
        tick();
        for (int i = 0; i < 20; i++) tick();
        check("t5_ret_b", int'(retired_b), 15);
        check("t5_ret_a", int'(retired_a), 20);
        run = 1'b0;
        tick();
        check("t5_ret_b_hold", int'(retired_b), 15);
        check("t5_ret_a_last", int'(retired_a), 21);
        check("t5_idle_pc_en", int'(pc_en_a), 0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 7) == 0) run = ~run;
            step_req = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 31);
            if (r < 14)      op = 6'(32 + $urandom_range(0, 31));
            else if (r < 18) op = 6'd0;
            else if (r < 20) op = 6'd1;
            else if (r < 22) op = 6'd2;
            else if (r < 24) op = 6'd3;
            else if (r < 29) op = 6'd4;
            else if (r < 30) op = 6'd5;
            else             op = 6'($urandom_range(6, 31));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
